issue_sched: RTL and testbench

Issue scheduler for the Qu back-end, directly downstream of the reservation station. It tracks occupancy and operand readiness for every reservation-station entry by snooping front-end allocations and common-data-bus (CDB) broadcasts. Each cycle it selects one ready entry in round-robin order and reads that entry through reservation-station read port 1. It then presents the entry to the execution unit over a valid/ready handshake and releases the slot back to the front end.

---
 rtl/issue_sched_pkg.sv | 26 ++
 rtl/issue_sched_rr_arbiter.sv | 30 +++
 rtl/issue_sched.sv | 151 +++++++++++++++
 tb/tb_issue_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// Shared back-end types for the reservation station and issue scheduler:
// entry index and physical-tag widths, the entry payload, and the
// round-robin pointer helper used by the arbiters.
package issue_sched_pkg;

    localparam int RES_ST_DEPTH      = 16;
    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int RES_ST_IDX_W      = $clog2(RES_ST_DEPTH);

    typedef logic [RES_ST_IDX_W-1:0]      res_st_addr_t;
    typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_tag_t;

    typedef struct packed {
        logic [7:0]  opcode;
        phy_tag_t    dst_tag;
        phy_tag_t    src1_tag;
        phy_tag_t    src2_tag;
        logic [15:0] imm;
    } res_st_cell_t;

    // Next round-robin base after a grant; wraps because the depth is a power of two.
    function automatic res_st_addr_t rr_next(input res_st_addr_t idx);
        return idx + res_st_addr_t'(1);
    endfunction

endpackage

// File: rtl/issue_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above i_base,
// wrapping around. Purely combinational; also used by the CDB arbiter.
module rr_arbiter
    import issue_sched_pkg::*;
#(
    parameter int N     = RES_ST_DEPTH,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_base,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Scan from the farthest offset down to i_base so the nearest request wins.
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i_base + IDX_W'(i)]) begin
                o_valid = 1'b1;
                o_idx   = i_base + IDX_W'(i);
            end
        end
        o_grant = N'(o_valid) << o_idx;
    end

endmodule

// File: rtl/issue_sched.sv
// Issue scheduler: tracks reservation-station occupancy and operand
// readiness, selects one ready entry per cycle in round-robin order, reads
// it through res_st read port 1 and holds it in a valid/ready output stage.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int RES_ST_DEPTH      = issue_sched_pkg::RES_ST_DEPTH,
    parameter int PHY_RF_ADDR_WIDTH = issue_sched_pkg::PHY_RF_ADDR_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_flush,
    input  logic                         i_alloc_en,
    input  res_st_addr_t                 i_alloc_addr,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] i_alloc_src1_tag,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] i_alloc_src2_tag,
    input  logic                         i_alloc_src1_rdy,
    input  logic                         i_alloc_src2_rdy,
    input  logic                         i_cdb_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] i_cdb_tag,
    output logic                         o_free_valid,
    output res_st_addr_t                 o_free_addr,
    output logic                         o_alloc_err,
    output res_st_addr_t                 o_rd_addr,
    input  res_st_cell_t                 i_rd_data,
    output logic                         o_iss_valid,
    input  logic                         i_iss_ready,
    output res_st_addr_t                 o_iss_addr,
    output res_st_cell_t                 o_iss_cell
);

    localparam int IDX_W = $clog2(RES_ST_DEPTH);

    logic [RES_ST_DEPTH-1:0]      r_busy, r_pend, r_rdy1, r_rdy2;
    logic [PHY_RF_ADDR_WIDTH-1:0] r_tag1 [RES_ST_DEPTH];
    logic [PHY_RF_ADDR_WIDTH-1:0] r_tag2 [RES_ST_DEPTH];
    res_st_addr_t                 r_rr_ptr;
    logic                         r_iss_valid;
    res_st_addr_t                 r_iss_addr;
    res_st_cell_t                 r_iss_cell;
    logic                         r_alloc_err;

    logic [RES_ST_DEPTH-1:0] w_elig, w_grant, w_clr;
    res_st_addr_t            w_win_idx;
    logic                    w_win_valid, w_sel;
    logic                    w_alloc_ok, w_alloc_rdy1, w_alloc_rdy2;

    // Eligibility uses registered state only, so same-cycle allocs/wakeups issue a cycle later.
    assign w_elig       = r_pend & r_rdy1 & r_rdy2;
    assign w_sel        = w_win_valid && (!r_iss_valid || i_iss_ready);
    assign w_clr        = w_sel ? w_grant : '0;
    assign w_alloc_ok   = i_alloc_en && !r_busy[i_alloc_addr];
    // A broadcast in the allocation cycle must not be lost for the new entry.
    assign w_alloc_rdy1 = i_alloc_src1_rdy || (i_cdb_valid && (i_cdb_tag == i_alloc_src1_tag));
    assign w_alloc_rdy2 = i_alloc_src2_rdy || (i_cdb_valid && (i_cdb_tag == i_alloc_src2_tag));

    rr_arbiter #(
        .N     (RES_ST_DEPTH),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (w_elig),
        .i_base  (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    // Lowest-index free slot for the front end.
    always_comb begin
        o_free_valid = ~&r_busy;
        o_free_addr  = '0;
        for (int i = RES_ST_DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) o_free_addr = res_st_addr_t'(i);
        end
    end

    assign o_rd_addr   = w_sel ? w_win_idx : r_rr_ptr;
    assign o_iss_valid = r_iss_valid;
    assign o_iss_addr  = r_iss_addr;
    assign o_iss_cell  = r_iss_cell;
    assign o_alloc_err = r_alloc_err;

    // Per-entry state: allocation, CDB wakeup, release on select, squash on flush.
    // NOTE: sequential state uses non-blocking assignments so every bit samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
            r_pend <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
            // NOTE: the tag arrays are small flops, so they are reset with the rest of the entry state.
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                r_tag1[i] <= '0;
                r_tag2[i] <= '0;
            end
        end else if (i_flush) begin
            r_busy <= '0;
            r_pend <= '0;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
        end else begin
            for (int i = 0; i < RES_ST_DEPTH; i++) begin
                if (i_cdb_valid && r_pend[i] && (r_tag1[i] == i_cdb_tag)) r_rdy1[i] <= 1'b1;
                if (i_cdb_valid && r_pend[i] && (r_tag2[i] == i_cdb_tag)) r_rdy2[i] <= 1'b1;
                if (w_alloc_ok && (i_alloc_addr == res_st_addr_t'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_pend[i] <= 1'b1;
                    r_rdy1[i] <= w_alloc_rdy1;
                    r_rdy2[i] <= w_alloc_rdy2;
                    r_tag1[i] <= i_alloc_src1_tag;
                    r_tag2[i] <= i_alloc_src2_tag;
                end
                if (w_clr[i]) begin
                    r_busy[i] <= 1'b0;
                    r_pend[i] <= 1'b0;
                    r_rdy1[i] <= 1'b0;
                    r_rdy2[i] <= 1'b0;
                end
            end
        end
    end

    // Output stage and round-robin pointer; the pointer survives a flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss_addr  <= '0;
            r_iss_cell  <= '0;
            r_rr_ptr    <= '0;
        end else if (i_flush) begin
            r_iss_valid <= 1'b0;
        end else if (w_sel) begin
            r_iss_valid <= 1'b1;
            r_iss_addr  <= w_win_idx;
            r_iss_cell  <= i_rd_data;
            r_rr_ptr    <= rr_next(w_win_idx);
        end else if (i_iss_ready) begin
            r_iss_valid <= 1'b0;
        end
    end

    // Sticky error for an allocation aimed at an occupied slot; only reset clears it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alloc_err <= 1'b0;
        end else if (i_alloc_en && r_busy[i_alloc_addr]) begin
            r_alloc_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_sched.sv
// Directed testbench for issue_sched with a behavioural res_st read port.
module tb_issue_sched;
    import issue_sched_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         alloc_en = 1'b0;
    res_st_addr_t alloc_addr = '0;
    phy_tag_t     alloc_src1_tag = '0, alloc_src2_tag = '0;
    logic         alloc_src1_rdy = 1'b0, alloc_src2_rdy = 1'b0;
    logic         cdb_valid = 1'b0;
    phy_tag_t     cdb_tag = '0;
    logic         free_valid, alloc_err, iss_valid;
    res_st_addr_t free_addr, rd_addr, iss_addr;
    res_st_cell_t rd_data, iss_cell;
    logic         iss_ready = 1'b0;

    res_st_cell_t mem [RES_ST_DEPTH];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           seq     = 0;

    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;

    issue_sched dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_flush          (flush),
        .i_alloc_en       (alloc_en),
        .i_alloc_addr     (alloc_addr),
        .i_alloc_src1_tag (alloc_src1_tag),
        .i_alloc_src2_tag (alloc_src2_tag),
        .i_alloc_src1_rdy (alloc_src1_rdy),
        .i_alloc_src2_rdy (alloc_src2_rdy),
        .i_cdb_valid      (cdb_valid),
        .i_cdb_tag        (cdb_tag),
        .o_free_valid     (free_valid),
        .o_free_addr      (free_addr),
        .o_alloc_err      (alloc_err),
        .o_rd_addr        (rd_addr),
        .i_rd_data        (rd_data),
        .o_iss_valid      (iss_valid),
        .i_iss_ready      (iss_ready),
        .o_iss_addr       (iss_addr),
        .o_iss_cell       (iss_cell)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        alloc_en  = 1'b0;
        cdb_valid = 1'b0;
        iss_ready = 1'b0;
        for (int i = 0; i < RES_ST_DEPTH; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One-cycle allocation; the entry payload goes into the bench res_st copy.
    task automatic alloc(input int addr, input int t1, input logic r1, input int t2, input logic r2);
        seq++;
        alloc_addr     = res_st_addr_t'(addr);
        alloc_src1_tag = phy_tag_t'(t1);
        alloc_src2_tag = phy_tag_t'(t2);
        alloc_src1_rdy = r1;
        alloc_src2_rdy = r2;
        alloc_en       = 1'b1;
        if (!(r1 !== 1'b1 && 0)) begin
            mem[addr] = '{opcode: 8'(seq), dst_tag: phy_tag_t'(addr + 32), src1_tag: phy_tag_t'(t1),
                          src2_tag: phy_tag_t'(t2), imm: 16'hA000 + 16'(addr)};
        end
        tick();
        alloc_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL reset_iss_valid: got %0b want 0", iss_valid); end
        n_tests++; if (iss_addr !== '0) begin n_fail++; $display("FAIL reset_iss_addr: got %0d want 0", iss_addr); end
        n_tests++; if (iss_cell !== '0) begin n_fail++; $display("FAIL reset_iss_cell: got %h want 0", iss_cell); end
        n_tests++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL reset_alloc_err: got %0b want 0", alloc_err); end
        n_tests++; if (free_valid !== 1'b1) begin n_fail++; $display("FAIL reset_free_valid: got %0b want 1", free_valid); end
        n_tests++; if (free_addr !== '0) begin n_fail++; $display("FAIL reset_free_addr: got %0d want 0", free_addr); end
        n_tests++; if (rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    endtask

    task automatic test_min_latency();
        do_reset();
        iss_ready = 1'b1;
        alloc(3, 1, 1'b1, 2, 1'b1);
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL minlat_early: got %0b want 0", iss_valid); end
        tick();
        n_tests++; if (iss_valid !== 1'b1) begin n_fail++; $display("FAIL minlat_valid: got %0b want 1", iss_valid); end
        n_tests++; if (iss_addr !== 4'd3) begin n_fail++; $display("FAIL minlat_addr: got %0d want 3", iss_addr); end
        n_tests++; if (iss_cell !== mem[3]) begin n_fail++; $display("FAIL minlat_cell: got %h want %h", iss_cell, mem[3]); end
        tick();
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL minlat_drain: got %0b want 0", iss_valid); end
        n_tests++; if (free_valid !== 1'b1 || free_addr !== '0) begin n_fail++; $display("FAIL minlat_free: got %0b/%0d want 1/0", free_valid, free_addr); end
    endtask

    task automatic test_wakeup();
        do_reset();
        iss_ready = 1'b1;
        alloc(2, 7, 1'b0, 3, 1'b1);
        alloc(5, 7, 1'b0, 3, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 6'd8;
        tick();
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wrong_tag: got %0b want 0", iss_valid); end
        cdb_tag = 6'd7;
        tick();
        cdb_valid = 1'b0;
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_latency: got %0b want 0", iss_valid); end
        tick();
        n_tests++; if (iss_valid !== 1'b1 || iss_addr !== 4'd2) begin n_fail++; $display("FAIL wake_first: got v=%0b a=%0d want v=1 a=2", iss_valid, iss_addr); end
        n_tests++; if (iss_cell !== mem[2]) begin n_fail++; $display("FAIL wake_first_cell: got %h want %h", iss_cell, mem[2]); end
        tick();
        n_tests++; if (iss_valid !== 1'b1 || iss_addr !== 4'd5) begin n_fail++; $display("FAIL wake_second: got v=%0b a=%0d want v=1 a=5", iss_valid, iss_addr); end
        n_tests++; if (rd_addr !== 4'd6) begin n_fail++; $display("FAIL wake_rr_ptr: got %0d want 6", rd_addr); end
        tick();
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL wake_drain: got %0b want 0", iss_valid); end
    endtask

    task automatic test_same_cycle_wakeup();
        do_reset();
        iss_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd9;
        alloc(0, 9, 1'b0, 4, 1'b1);
        cdb_tag = 6'd11;
        alloc(1, 2, 1'b1, 11, 1'b0);
        cdb_valid = 1'b0;
        n_tests++; if (iss_valid !== 1'b1 || iss_addr !== 4'd0) begin n_fail++; $display("FAIL same_cyc_src1: got v=%0b a=%0d want v=1 a=0", iss_valid, iss_addr); end
        tick();
        n_tests++; if (iss_valid !== 1'b1 || iss_addr !== 4'd1) begin n_fail++; $display("FAIL same_cyc_src2: got v=%0b a=%0d want v=1 a=1", iss_valid, iss_addr); end
        tick();
    endtask

    task automatic test_back_to_back();
        res_st_cell_t first0;
        do_reset();
        iss_ready = 1'b0;
        for (int i = 0; i < RES_ST_DEPTH; i++) alloc(i, 1, 1'b1, 1, 1'b1);
        first0 = '{opcode: 8'(seq - 15), dst_tag: 6'd32, src1_tag: 6'd1, src2_tag: 6'd1, imm: 16'hA000};
        alloc(0, 1, 1'b1, 1, 1'b1);
        n_tests++; if (free_valid !== 1'b0) begin n_fail++; $display("FAIL full_free_valid: got %0b want 0", free_valid); end
        repeat (5) tick();
        n_tests++; if (iss_valid !== 1'b1 || iss_addr !== 4'd0) begin n_fail++; $display("FAIL full_hold: got v=%0b a=%0d want v=1 a=0", iss_valid, iss_addr); end
        n_tests++; if (iss_cell !== first0) begin n_fail++; $display("FAIL full_hold_cell: got %h want %h", iss_cell, first0); end
        iss_ready = 1'b1;
        for (int k = 1; k <= RES_ST_DEPTH; k++) begin
            tick();
            n_tests++;
            if (iss_valid !== 1'b1 || iss_addr !== res_st_addr_t'(k)) begin
                n_fail++; $display("FAIL b2b_issue_%0d: got v=%0b a=%0d want v=1 a=%0d", k, iss_valid, iss_addr, k % RES_ST_DEPTH);
            end
        end
        n_tests++; if (iss_cell !== mem[0]) begin n_fail++; $display("FAIL b2b_realloc_cell: got %h want %h", iss_cell, mem[0]); end
        tick();
        n_tests++; if (iss_valid !== 1'b0 || free_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got v=%0b fv=%0b want 0/1", iss_valid, free_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        iss_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            alloc((k % 2 == 0) ? 1 : 4, 5, 1'b1, 5, 1'b1);
            if (k >= 1) begin
                n_tests++;
                if (iss_valid !== 1'b1 || iss_addr !== ((k % 2 == 1) ? 4'd1 : 4'd4)) begin
                    n_fail++; $display("FAIL rr_%0d: got v=%0b a=%0d want v=1 a=%0d", k, iss_valid, iss_addr, (k % 2 == 1) ? 1 : 4);
                end
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_flush_and_err();
        do_reset();
        iss_ready = 1'b0;
        for (int i = 0; i < 7; i++) alloc(i, 1, 1'b1, 1, 1'b1);
        alloc(0, 1, 1'b1, 1, 1'b1);
        n_tests++; if (iss_valid !== 1'b1 || free_addr !== 4'd7) begin n_fail++; $display("FAIL pre_flush: got v=%0b fa=%0d want v=1 fa=7", iss_valid, free_addr); end
        flush = 1'b1;
        alloc(7, 1, 1'b1, 1, 1'b1);
        flush = 1'b0;
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_iss_valid: got %0b want 0", iss_valid); end
        n_tests++; if (free_valid !== 1'b1 || free_addr !== 4'd0) begin n_fail++; $display("FAIL flush_free: got %0b/%0d want 1/0", free_valid, free_addr); end
        iss_ready = 1'b1;
        repeat (2) tick();
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_stale: got %0b want 0", iss_valid); end
        n_tests++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %0b want 0", alloc_err); end
        alloc(2, 20, 1'b0, 1, 1'b1);
        n_tests++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL err_first_alloc: got %0b want 0", alloc_err); end
        alloc(2, 21, 1'b1, 1, 1'b1);
        n_tests++; if (alloc_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %0b want 1", alloc_err); end
        repeat (2) tick();
        n_tests++; if (iss_valid !== 1'b0) begin n_fail++; $display("FAIL err_state_unchanged: got %0b want 0", iss_valid); end
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        n_tests++; if (alloc_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0b want 1", alloc_err); end
        do_reset();
        n_tests++; if (alloc_err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %0b want 0", alloc_err); end
    endtask

    initial begin
        test_reset();
        test_min_latency();
        test_wakeup();
        test_same_cycle_wakeup();
        test_back_to_back();
        test_round_robin();
        test_flush_and_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
